regfile_sb: RTL and testbench

- Parametrised successor to the 16x16 CPU register file; sits between decode (read/claim) and write-back.
- Adds configurable width, depth and read-port count.
- Adds async reset, an enabled EPC side port, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for hazard detection.

---
 rtl/regfile_sb_if.sv | 30 +++
 rtl/regfile_sb.sv | 86 ++++++++
 tb/tb_regfile_sb.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bundle of read, write, EPC and scoreboard signals between the pipeline and regfile_sb.
// The master drives indices, write data and scoreboard controls; the slave returns data and busy flags.
interface regfile_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rdaddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     regwrite;
  logic [ADDR_W-1:0]        wrreg;
  logic [DATA_W-1:0]        wdata;
  logic                     epc_we;
  logic [DATA_W-1:0]        epc;
  logic                     claim;
  logic [ADDR_W-1:0]        claim_reg;
  logic                     flush;
  logic [(2**ADDR_W)-1:0]   busy;

  modport master (
    output rdaddr, regwrite, wrreg, wdata, epc_we, epc, claim, claim_reg, flush,
    input  rdata, rbusy, busy
  );

  modport slave (
    input  rdaddr, regwrite, wrreg, wdata, epc_we, epc, claim, claim_reg, flush,
    output rdata, rbusy, busy
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with an EPC side port, optional write-to-read bypass
// and a per-register busy scoreboard for hazard detection.
module regfile_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int NUM_RD  = 2,
  parameter int EPC_IDX = 12,
  parameter int BYPASS  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);
  localparam int NUM_REG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] EPC_ADDR = ADDR_W'(EPC_IDX);

  logic [DATA_W-1:0]  regs [NUM_REG];
  logic [NUM_REG-1:0] busy_q;
  logic [NUM_REG-1:0] busy_d;
  logic               gen_we;
  logic               byp_en;

  // The EPC port owns its register when both ports target it on the same edge.
  assign gen_we = bus.regwrite && !(bus.epc_we && (bus.wrreg == EPC_ADDR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REG; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (gen_we) begin
        regs[bus.wrreg] <= bus.wdata;
      end
      if (bus.epc_we) begin
        regs[EPC_ADDR] <= bus.epc;
      end
      busy_q <= busy_d;
    end
  end

  // A claim on the same edge as a write to that register is the newer producer.
  always_comb begin
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (bus.regwrite) begin
        busy_d[bus.wrreg] = 1'b0;
      end
      if (bus.claim) begin
        busy_d[bus.claim_reg] = 1'b1;
      end
    end
  end

  assign bus.busy = busy_q;

  // Bypass is held off during reset so every read output reads as zero.
  assign byp_en = (BYPASS != 0) && rst_n;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rb;

    assign addr = bus.rdaddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = regs[addr];
      rb   = busy_q[addr];
      if (byp_en) begin
        if (bus.epc_we && (addr == EPC_ADDR)) begin
          data = bus.epc;
        end else if (bus.regwrite && (addr == bus.wrreg)) begin
          data = bus.wdata;
          rb   = 1'b0;
        end
      end
    end

    assign bus.rdata[k*DATA_W +: DATA_W] = data;
    assign bus.rbusy[k]                  = rb;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three instances (bypass, no bypass, 32-bit/4-port) share one stimulus
// stream and are compared every cycle against an array-based model, plus literal checkpoints.
module tb_regfile_sb;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) bus_a ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) bus_b ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(4)) bus_c ();

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .EPC_IDX(12), .BYPASS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  regfile_sb #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .EPC_IDX(12), .BYPASS(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  regfile_sb #(.DATA_W(32), .ADDR_W(4), .NUM_RD(4), .EPC_IDX(12), .BYPASS(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  // shared stimulus, at the widest configuration
  logic [3:0]  ra [4];
  logic        we, ewe, clm, fl;
  logic [3:0]  wr, creg;
  logic [31:0] wd, ed;

  assign bus_a.rdaddr = {ra[1], ra[0]};
  assign bus_b.rdaddr = {ra[1], ra[0]};
  assign bus_c.rdaddr = {ra[3], ra[2], ra[1], ra[0]};
  assign bus_a.regwrite = we;   assign bus_b.regwrite = we;   assign bus_c.regwrite = we;
  assign bus_a.wrreg = wr;      assign bus_b.wrreg = wr;      assign bus_c.wrreg = wr;
  assign bus_a.wdata = wd[15:0]; assign bus_b.wdata = wd[15:0]; assign bus_c.wdata = wd;
  assign bus_a.epc_we = ewe;    assign bus_b.epc_we = ewe;    assign bus_c.epc_we = ewe;
  assign bus_a.epc = ed[15:0];  assign bus_b.epc = ed[15:0];  assign bus_c.epc = ed;
  assign bus_a.claim = clm;     assign bus_b.claim = clm;     assign bus_c.claim = clm;
  assign bus_a.claim_reg = creg; assign bus_b.claim_reg = creg; assign bus_c.claim_reg = creg;
  assign bus_a.flush = fl;      assign bus_b.flush = fl;      assign bus_c.flush = fl;

  // model: 32-bit contents (16-bit instances see the low half) and one busy set
  logic [31:0] mem [16];
  logic [15:0] bsy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      bsy = '0;
    end else begin
      if (we && !(ewe && wr == 4'd12)) mem[wr] = wd;
      if (ewe) mem[12] = ed;
      for (int i = 0; i < 16; i++) begin
        if (fl) bsy[i] = 1'b0;
        else if (clm && creg == 4'(i)) bsy[i] = 1'b1;
        else if (we && wr == 4'(i)) bsy[i] = 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [3:0] a, input bit byp);
    if (byp && rst_n && ewe && a == 4'd12) return ed;
    if (byp && rst_n && we && a == wr) return wd;
    return mem[a];
  endfunction

  function automatic logic exp_rb(input logic [3:0] a, input bit byp);
    if (byp && rst_n && !(ewe && a == 4'd12) && we && a == wr) return 1'b0;
    return bsy[a];
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [31:0]  ea_rd, eb_rd, t;
    logic [1:0]   ea_rb, eb_rb;
    logic [127:0] ec_rd;
    logic [3:0]   ec_rb;
    ea_rd = '0; eb_rd = '0; ea_rb = '0; eb_rb = '0; ec_rd = '0; ec_rb = '0;
    for (int k = 0; k < 4; k++) begin
      t = exp_rd(ra[k], 1'b1);
      ec_rd[k*32 +: 32] = t;
      ec_rb[k] = exp_rb(ra[k], 1'b1);
      if (k < 2) begin
        ea_rd[k*16 +: 16] = t[15:0];
        ea_rb[k] = exp_rb(ra[k], 1'b1);
        t = exp_rd(ra[k], 1'b0);
        eb_rd[k*16 +: 16] = t[15:0];
        eb_rb[k] = exp_rb(ra[k], 1'b0);
      end
    end
    chk("a_rdata", bus_a.rdata, ea_rd);
    chk("a_rbusy", bus_a.rbusy, ea_rb);
    chk("a_busy",  bus_a.busy,  bsy);
    chk("b_rdata", bus_b.rdata, eb_rd);
    chk("b_rbusy", bus_b.rbusy, eb_rb);
    chk("b_busy",  bus_b.busy,  bsy);
    chk("c_rdata", bus_c.rdata, ec_rd);
    chk("c_rbusy", bus_c.rbusy, ec_rb);
    chk("c_busy",  bus_c.busy,  bsy);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; ewe = 1'b0; clm = 1'b0; fl = 1'b0;
  endtask

  task automatic rand_stim();
    wr = 4'($urandom_range(0, 15));
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 4))
        0:       ra[k] = wr;
        1:       ra[k] = 4'd12;
        default: ra[k] = 4'($urandom_range(0, 15));
      endcase
    end
    we   = ($urandom_range(0, 1) == 1);
    wd   = $urandom();
    ewe  = ($urandom_range(0, 5) == 0);
    ed   = $urandom();
    clm  = ($urandom_range(0, 2) == 0);
    creg = ($urandom_range(0, 3) == 0) ? wr : 4'($urandom_range(0, 15));
    fl   = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) ra[k] = '0;
    idle();
    wr = '0; wd = '0; ed = '0; creg = '0;
    #1;
    // reset while reading 3 and 12, with a write pending
    rst_n = 1'b0;
    ra[0] = 4'd3; ra[1] = 4'd12;
    we = 1'b1; wr = 4'd3; wd = 32'h0000BEEF;
    #2;
    chk("rst_rdata_a", bus_a.rdata, 32'h0);
    chk("rst_busy_a", bus_a.busy, 16'h0);
    cyc();
    rst_n = 1'b1;
    ra[0] = 4'd0;
    cyc();
    idle(); ra[0] = 4'd3;
    #2;
    chk("beef_rd_a", bus_a.rdata[15:0], 16'hBEEF);
    chk("beef_rd_b", bus_b.rdata[15:0], 16'hBEEF);

    // same-cycle bypass versus stored value
    we = 1'b1; wr = 4'd5; wd = 32'h00001234; ra[1] = 4'd5;
    #2;
    chk("byp_a", bus_a.rdata[31:16], 16'h1234);
    chk("nobyp_b", bus_b.rdata[31:16], 16'h0000);
    cyc();
    idle();
    #2;
    chk("after_b", bus_b.rdata[31:16], 16'h1234);

    // EPC beats the general write to reg 12, then holds while disabled
    we = 1'b1; wr = 4'd12; wd = 32'h00000001; ewe = 1'b1; ed = 32'h00008000;
    cyc();
    idle(); ed = 32'h0000FFFF; ra[0] = 4'd12;
    repeat (5) cyc();
    chk("epc_hold_a", bus_a.rdata[15:0], 16'h8000);
    chk("epc_model", mem[12][15:0], 16'h8000);

    // claim 7, write it two cycles later
    clm = 1'b1; creg = 4'd7;
    cyc();
    idle(); ra[0] = 4'd7;
    #2;
    chk("claim7_rbusy", bus_a.rbusy[0], 1'b1);
    cyc();
    we = 1'b1; wr = 4'd7; wd = 32'h000000AA;
    #2;
    chk("wr7_rbusy_a", bus_a.rbusy[0], 1'b0);
    chk("wr7_rdata_a", bus_a.rdata[15:0], 16'h00AA);
    chk("wr7_rbusy_b", bus_b.rbusy[0], 1'b1);
    cyc();
    idle();
    #2;
    chk("busy7_clear", bus_a.busy[7], 1'b0);

    // claim and write same register on one edge
    clm = 1'b1; creg = 4'd2; we = 1'b1; wr = 4'd2; wd = 32'h00000055;
    cyc();
    idle();
    #2;
    chk("claim_wins", bus_a.busy[2], 1'b1);
    foreach (ra[k]) ra[k] = '0;
    clm = 1'b1; creg = 4'd1; cyc();
    creg = 4'd4; cyc();
    creg = 4'd9; cyc();
    clm = 1'b0;
    #2;
    chk("busy_set", bus_a.busy, 16'h0216);
    fl = 1'b1; clm = 1'b1; creg = 4'd6;
    cyc();
    idle();
    #2;
    chk("flush", bus_c.busy, 16'h0000);

    // 32-bit, 4-port fill and readback
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wr = 4'(i); wd = i * 32'h01010101;
      cyc();
    end
    idle();
    ra[0] = 4'd0; ra[1] = 4'd15; ra[2] = 4'd15; ra[3] = 4'd8;
    #2;
    chk("c_fill", bus_c.rdata, {32'h08080808, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h00000000});
    we = 1'b1; wr = 4'd15; wd = 32'h12345678;
    rst_n = 1'b0;
    #1;
    chk("midrst_c_rd", bus_c.rdata, 128'h0);
    chk("midrst_c_rb", bus_c.rbusy, 4'h0);
    chk("midrst_a_rd", bus_a.rdata, 32'h0);
    cyc();
    rst_n = 1'b1;
    idle();

    // randomized run with an asynchronous reset pulse partway through
    for (int n = 0; n < 1500; n++) begin
      rand_stim();
      if (n == 700) rst_n = 1'b0;
      if (n == 702) rst_n = 1'b1;
      cyc();
    end
    idle();
    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
